adc_scan_sequencer: RTL and testbench
=====================================

// Module: adc_scan_sequencer
// PURPOSE
//  Autonomous scan controller for the SAR ADC and its 8:1 analog input mux (AN0..AN7).
//  Walks the enabled channels, drives adc_mux_sel, waits a programmable settle time,
//  fires start-of-conversion and captures {channel, result} into a result FIFO.
//  Sits between the APB ADC register block (config/FIFO pop) and the ADC macro, so
//  firmware no longer bit-bangs mux_sel/SOC per sample.
// PARAMETERS
//  NCH        8     number of mux channels (CH_W = $clog2(NCH))
//  DW         10    ADC result width
//  DEPTH      8     result FIFO entries (power of 2)
//  SETTLE_W   8     width of settle-cycle count
//  EOC_TMO    1024  HCLK cycles to wait for adc_eoc before declaring timeout
// PORTS
//  HCLK         in   1         system clock
//  HRESETn      in   1         asynchronous, active-low reset
//  en           in   1         sequencer enable (level)
//  trig         in   1         one-cycle pulse: start one scan (single mode)
//  cont         in   1         1 = continuous scanning while en
//  ch_mask      in   NCH       channels in scan; bit i = channel i
//  settle       in   SETTLE_W  settle cycles after mux change
//  adc_mux_sel  out  CH_W      ADC input mux select
//  adc_soc      out  1         start-of-conversion, one-cycle pulse
//  adc_eoc      in   1         end-of-conversion pulse from ADC
//  adc_data     in   DW        conversion result, valid with adc_eoc
//  fifo_rd      in   1         pop head entry
//  fifo_dout    out  CH_W+DW   head entry {ch, data}, show-ahead
//  fifo_level   out  $clog2(DEPTH)+1  entries held
//  fifo_empty   out  1         level == 0
//  err_clr      in   1         clears ovf and tmo
//  ovf          out  1         sticky: sample dropped, FIFO full
//  tmo          out  1         sticky: EOC timeout occurred
//  busy         out  1         state != IDLE
//  scan_done    out  1         one-cycle pulse after last channel of a scan
// BEHAVIOUR
//  Reset: state IDLE; adc_mux_sel=0, adc_soc=0, busy=0, scan_done=0, ovf=0, tmo=0,
//   FIFO empty (level=0, fifo_empty=1, fifo_dout=0).
//  FSM: IDLE -> SELECT -> SETTLE -> CONVERT -> WAIT_EOC -> (SELECT | IDLE).
//  IDLE: if en && (trig || cont) && ch_mask!=0: latch ch_mask into scan_mask,
//   ch = lowest set bit -> SELECT. ch_mask==0: stay IDLE, no scan_done.
//  SELECT: adc_mux_sel <= ch; settle counter <= settle -> SETTLE.
//  SETTLE: decrement; at 0 -> CONVERT (settle=0 gives zero wait cycles).
//  CONVERT: adc_soc=1 for exactly one cycle; timeout counter cleared -> WAIT_EOC.
//  Latency: adc_soc high in cycle T+2+settle, where T = trig-sampling edge.
//  WAIT_EOC: on adc_eoc push {ch, adc_data}; then next = next set bit above ch in
//   scan_mask. None left: scan_done pulse; go SELECT(lowest) if en && cont, else IDLE.
//   Counter reaching EOC_TMO: set tmo, push nothing, advance as if eoc seen.
//  en low mid-scan: current conversion completes (eoc or timeout) and its sample is
//   pushed, then IDLE; no scan_done. ch_mask/settle changes affect only the next scan.
//  trig while busy: ignored (not queued).
//  FIFO: push when full drops the sample and sets ovf. Simultaneous push+pop when
//   full: both accepted, no ovf. Pop when empty: ignored, level stays 0.
//   Pointers wrap modulo DEPTH.
//  err_clr has priority below a same-cycle set: a new event wins.
//  Reset mid-operation aborts immediately; adc_soc drops asynchronously.
// STRUCTURE
//  Package adc_seq_pkg: state enum (IDLE, SELECT, SETTLE, CONVERT, WAIT_EOC),
//   entry width localparam, find-next-set-bit function.
//  Sub-module adc_seq_fifo: synchronous show-ahead FIFO with level/full/empty.
//  Top: FSM, settle/timeout counters, scan_mask/ch registers, sticky flags.
// TESTING
//  1. ch_mask=8'h05, settle=3, trig: soc at T+5; FIFO gets {0,d0},{2,d2}; scan_done once.
//  2. cont=1, ch_mask=8'h80: repeated ch7 samples; drop en mid-conversion -> one last
//     push, then IDLE, no scan_done.
//  3. No fifo_rd, 9 samples with DEPTH=8: level=8, ovf=1; push+pop when full -> ovf stays.
//  4. Suppress adc_eoc: tmo set after 1024 cycles, channel skipped, scan continues.
//  5. ch_mask=0 + trig -> busy stays 0; trig while busy -> no second scan.
//  6. Assert HRESETn low during SETTLE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared types, defaults and helpers for the ADC scan sequencer
// Purpose: FSM state encoding, default geometry, FIFO entry width and the
//          find-next-set-bit helper used to walk the channel mask.
// Ports:   none (package)
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    SETTLE   = 3'd2,
    CONVERT  = 3'd3,
    WAIT_EOC = 3'd4
  } seq_state_e;

  localparam int NCH_DEF      = 8;
  localparam int DW_DEF       = 10;
  localparam int DEPTH_DEF    = 8;
  localparam int SETTLE_W_DEF = 8;
  localparam int EOC_TMO_DEF  = 1024;
  localparam int ENTRY_W      = $clog2(NCH_DEF) + DW_DEF;

  // Index of the lowest set bit at or above 'from', or -1 when there is none.
  function automatic int find_next_set(input logic [31:0] mask, input int from);
    int r;
    r = -1;
    for (int i = 31; i >= 0; i--) begin
      if (i >= from && mask[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_seq_fifo.sv
// rtl/adc_seq_fifo.sv - synchronous show-ahead result FIFO
// Purpose: stores {channel, result} samples; head entry is visible on data_o.
// Ports:   clk_i/rst_ni clock and async active-low reset; push_i/data_i write;
//          pop_i read; data_o head entry (0 when empty); level_o entries held;
//          full_o/empty_o status.
module adc_seq_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a full FIFO still takes a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - autonomous SAR ADC channel scan controller
// Purpose: walks enabled mux channels, settles, fires SOC, captures results.
// Ports:   HCLK/HRESETn clock and async active-low reset; en/trig/cont/ch_mask/
//          settle scan control; adc_mux_sel/adc_soc/adc_eoc/adc_data ADC side;
//          fifo_rd/fifo_dout/fifo_level/fifo_empty result FIFO; err_clr/ovf/tmo
//          sticky errors; busy and scan_done status.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NCH      = NCH_DEF,
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF,
  parameter int EOC_TMO  = EOC_TMO_DEF,
  localparam int CH_W    = $clog2(NCH),
  localparam int EW      = CH_W + DW,
  localparam int LW      = $clog2(DEPTH) + 1,
  localparam int TMO_W   = $clog2(EOC_TMO)
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                en,
  input  logic                trig,
  input  logic                cont,
  input  logic [NCH-1:0]      ch_mask,
  input  logic [SETTLE_W-1:0] settle,
  output logic [CH_W-1:0]     adc_mux_sel,
  output logic                adc_soc,
  input  logic                adc_eoc,
  input  logic [DW-1:0]       adc_data,
  input  logic                fifo_rd,
  output logic [EW-1:0]       fifo_dout,
  output logic [LW-1:0]       fifo_level,
  output logic                fifo_empty,
  input  logic                err_clr,
  output logic                ovf,
  output logic                tmo,
  output logic                busy,
  output logic                scan_done
);

  seq_state_e          state_q;
  logic [NCH-1:0]      scan_mask_q;
  logic [SETTLE_W-1:0] settle_lat_q, settle_cnt_q;
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic [CH_W-1:0]     ch_q, mux_sel_q;
  logic                soc_q, done_q, ovf_q, tmo_q;

  int                  nxt_i, low_i;
  logic                push, drop, tmo_hit, fifo_full, conv_end;
  logic                start_ok, rescan_ok;

  always_comb begin
    nxt_i     = find_next_set(32'(scan_mask_q), int'(ch_q) + 1);
    low_i     = find_next_set(32'(ch_mask), 0);
    push      = (state_q == WAIT_EOC) && adc_eoc;
    tmo_hit   = (state_q == WAIT_EOC) && !adc_eoc && (tmo_cnt_q == TMO_W'(EOC_TMO - 1));
    conv_end  = push || tmo_hit;
    drop      = push && fifo_full && !fifo_rd;
    start_ok  = en && (trig || cont) && (ch_mask != '0);
    rescan_ok = cont && (ch_mask != '0);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      scan_mask_q  <= '0;
      settle_lat_q <= '0;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      ch_q         <= '0;
      mux_sel_q    <= '0;
      soc_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      soc_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            scan_mask_q  <= ch_mask;
            settle_lat_q <= settle;
            ch_q         <= CH_W'(low_i);
            state_q      <= SELECT;
          end
        end
        SELECT: begin
          mux_sel_q    <= ch_q;
          settle_cnt_q <= settle_lat_q;
          state_q      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt_q == '0) begin
            soc_q   <= 1'b1;
            state_q <= CONVERT;
          end else begin
            settle_cnt_q <= settle_cnt_q - SETTLE_W'(1);
          end
        end
        CONVERT: begin
          tmo_cnt_q <= '0;
          state_q   <= WAIT_EOC;
        end
        WAIT_EOC: begin
          if (conv_end) begin
            // Dropping en finishes only the conversion in flight; no done pulse.
            if (!en) begin
              state_q <= IDLE;
            end else if (nxt_i >= 0) begin
              ch_q    <= CH_W'(nxt_i);
              state_q <= SELECT;
            end else begin
              done_q <= 1'b1;
              if (rescan_ok) begin
                scan_mask_q  <= ch_mask;
                settle_lat_q <= settle;
                ch_q         <= CH_W'(low_i);
                state_q      <= SELECT;
              end else begin
                state_q <= IDLE;
              end
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky error flags: a same-cycle event beats err_clr.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      if (drop)         ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (tmo_hit)      tmo_q <= 1'b1;
      else if (err_clr) tmo_q <= 1'b0;
    end
  end

  adc_seq_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .push_i  (push),
    .data_i  ({ch_q, adc_data}),
    .pop_i   (fifo_rd),
    .data_o  (fifo_dout),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign adc_mux_sel = mux_sel_q;
  assign adc_soc     = soc_q;
  assign scan_done   = done_q;
  assign ovf         = ovf_q;
  assign tmo         = tmo_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - directed self-checking bench for adc_scan_sequencer
module tb_adc_scan_sequencer;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        en, trig, cont, adc_eoc, fifo_rd, err_clr;
  logic [7:0]  ch_mask, settle;
  logic [9:0]  adc_data;
  logic [2:0]  adc_mux_sel;
  logic        adc_soc, fifo_empty, ovf, tmo, busy, scan_done;
  logic [12:0] fifo_dout;
  logic [3:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  adc_scan_sequencer dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .en          (en),
    .trig        (trig),
    .cont        (cont),
    .ch_mask     (ch_mask),
    .settle      (settle),
    .adc_mux_sel (adc_mux_sel),
    .adc_soc     (adc_soc),
    .adc_eoc     (adc_eoc),
    .adc_data    (adc_data),
    .fifo_rd     (fifo_rd),
    .fifo_dout   (fifo_dout),
    .fifo_level  (fifo_level),
    .fifo_empty  (fifo_empty),
    .err_clr     (err_clr),
    .ovf         (ovf),
    .tmo         (tmo),
    .busy        (busy),
    .scan_done   (scan_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_soc();
    int n;
    n = 0;
    while (adc_soc !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("soc_seen", 32'(adc_soc), 32'd1);
  endtask

  task automatic do_conv(input logic [9:0] d);
    wait_soc();
    tick();
    adc_eoc  = 1'b1;
    adc_data = d;
    tick();
    adc_eoc  = 1'b0;
  endtask

  task automatic pop();
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
  endtask

  initial begin
    int socs;
    HRESETn = 1'b0; en = 1'b0; trig = 1'b0; cont = 1'b0; adc_eoc = 1'b0;
    fifo_rd = 1'b0; err_clr = 1'b0; ch_mask = 8'h00; settle = 8'd0; adc_data = '0;
    tick();
    tick();
    check("rst_busy",  32'(busy), 0);
    check("rst_soc",   32'(adc_soc), 0);
    check("rst_mux",   32'(adc_mux_sel), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_dout",  32'(fifo_dout), 0);
    check("rst_flags", {30'd0, ovf, tmo}, 0);
    HRESETn = 1'b1;
    tick();

    // 1: two-channel single scan, settle=3, exact SOC latency
    en = 1'b1; ch_mask = 8'h05; settle = 8'd3;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("t1_busy", 32'(busy), 1);
    repeat (4) tick();
    check("t1_soc_early", 32'(adc_soc), 0);
    tick();
    check("t1_soc_t5", 32'(adc_soc), 1);
    check("t1_mux0", 32'(adc_mux_sel), 0);
    tick();
    check("t1_soc_pulse", 32'(adc_soc), 0);
    adc_eoc = 1'b1; adc_data = 10'h155;
    tick();
    adc_eoc = 1'b0;
    check("t1_level1", 32'(fifo_level), 1);
    check("t1_head0", 32'(fifo_dout), 32'h0155);
    do_conv(10'h2AA);
    check("t1_mux2", 32'(adc_mux_sel), 2);
    check("t1_done", 32'(scan_done), 1);
    check("t1_idle", 32'(busy), 0);
    check("t1_level2", 32'(fifo_level), 2);
    tick();
    check("t1_done_pulse", 32'(scan_done), 0);
    pop();
    check("t1_head2", 32'(fifo_dout), 32'h0AAA);
    pop();
    check("t1_empty", 32'(fifo_empty), 1);
    check("t1_dout0", 32'(fifo_dout), 0);

    // 2: continuous ch7, en dropped during the third conversion
    ch_mask = 8'h80; settle = 8'd2; cont = 1'b1;
    do_conv(10'h011);
    check("t2_done1", 32'(scan_done), 1);
    check("t2_mux7", 32'(adc_mux_sel), 7);
    do_conv(10'h022);
    check("t2_done2", 32'(scan_done), 1);
    wait_soc();
    tick();
    en = 1'b0;
    tick();
    tick();
    check("t2_still_busy", 32'(busy), 1);
    adc_eoc = 1'b1; adc_data = 10'h033;
    tick();
    adc_eoc = 1'b0;
    check("t2_idle", 32'(busy), 0);
    check("t2_no_done", 32'(scan_done), 0);
    check("t2_level3", 32'(fifo_level), 3);
    check("t2_head", 32'(fifo_dout), 32'h1C11);
    pop();
    pop();
    check("t2_last", 32'(fifo_dout), 32'h1C33);
    pop();
    check("t2_empty", 32'(fifo_empty), 1);

    // 3: overflow, set beats clear, then push+pop while full
    settle = 8'd0; en = 1'b1;
    for (int i = 1; i <= 8; i++) do_conv(10'(i));
    check("t3_level8", 32'(fifo_level), 8);
    check("t3_no_ovf", 32'(ovf), 0);
    wait_soc();
    tick();
    adc_eoc = 1'b1; adc_data = 10'd9; err_clr = 1'b1;
    tick();
    adc_eoc = 1'b0; err_clr = 1'b0;
    check("t3_ovf_wins", 32'(ovf), 1);
    check("t3_level_sat", 32'(fifo_level), 8);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3_ovf_clr", 32'(ovf), 0);
    wait_soc();
    tick();
    adc_eoc = 1'b1; adc_data = 10'd10; fifo_rd = 1'b1; en = 1'b0;
    tick();
    adc_eoc = 1'b0; fifo_rd = 1'b0;
    check("t3_pushpop_ovf", 32'(ovf), 0);
    check("t3_pushpop_lvl", 32'(fifo_level), 8);
    check("t3_head", 32'(fifo_dout), 32'h1C02);
    check("t3_idle", 32'(busy), 0);
    repeat (7) pop();
    check("t3_tail", 32'(fifo_dout), 32'h1C0A);
    pop();
    check("t3_drained", 32'(fifo_empty), 1);
    pop();
    check("t3_pop_empty", 32'(fifo_level), 0);
    cont = 1'b0;

    // 4: EOC timeout on ch1, scan continues on ch2
    en = 1'b1; ch_mask = 8'h06; settle = 8'd1;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    wait_soc();
    check("t4_mux1", 32'(adc_mux_sel), 1);
    tick();
    repeat (1023) tick();
    check("t4_tmo_early", 32'(tmo), 0);
    tick();
    check("t4_tmo", 32'(tmo), 1);
    check("t4_no_push", 32'(fifo_level), 0);
    check("t4_busy", 32'(busy), 1);
    do_conv(10'h3FF);
    check("t4_mux2", 32'(adc_mux_sel), 2);
    check("t4_entry", 32'(fifo_dout), 32'h0BFF);
    check("t4_done", 32'(scan_done), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_tmo_clr", 32'(tmo), 0);
    pop();

    // 5: empty mask ignored; trig while busy not queued
    ch_mask = 8'h00;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("t5_mask0_busy", 32'(busy), 0);
    tick();
    check("t5_mask0_done", {30'd0, busy, scan_done}, 0);
    ch_mask = 8'h01; settle = 8'd2;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    do_conv(10'h100);
    check("t5_idle", 32'(busy), 0);
    check("t5_level", 32'(fifo_level), 1);
    socs = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (adc_soc) socs++;
    end
    check("t5_no_rescan", 32'(socs), 0);

    // 6: reset asserted during SETTLE
    ch_mask = 8'h08; settle = 8'd10;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (3) tick();
    check("t6_mux3", 32'(adc_mux_sel), 3);
    check("t6_busy", 32'(busy), 1);
    #2;
    HRESETn = 1'b0;
    #1;
    check("t6_busy_rst", 32'(busy), 0);
    check("t6_mux_rst", 32'(adc_mux_sel), 0);
    check("t6_soc_rst", 32'(adc_soc), 0);
    check("t6_level_rst", 32'(fifo_level), 0);
    check("t6_empty_rst", 32'(fifo_empty), 1);
    check("t6_dout_rst", 32'(fifo_dout), 0);
    tick();
    HRESETn = 1'b1;
    en = 1'b0;
    tick();
    check("t6_after", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
